router_fsm: RTL and testbench

Control state machine for the 1x3 router input side. Decodes the header address, sequences the packet-register datapath through header, payload, FIFO-full stall and parity phases, and drives the write enable toward the three output FIFOs. Sits between the input port and the packet register; consumes FIFO status and synchronizer soft resets; produces the phase strobes the register block uses for latching, parity accumulation and error checking.

---
 rtl/router_pkg.sv | 19 +
 rtl/router_fsm.sv | 113 +++++++++++
 tb/tb_router_fsm.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router input-side control.
package router_pkg;

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        FIFO_FULL_STATE    = 4'd3,
        LOAD_AFTER_FULL    = 4'd4,
        LOAD_PARITY        = 4'd5,
        CHECK_PARITY_ERROR = 4'd6,
        WAIT_TILL_EMPTY    = 4'd7,
        DROP_PACKET        = 4'd8
    } state_e;

    localparam logic [1:0] ADDR_INVALID = 2'd3;
    localparam int         NUM_PORTS    = 3;

endpackage

// File: rtl/router_fsm.sv
// Router input-side sequencer: header decode, load/stall/parity phases and
// FIFO write enable, all as registered Moore outputs.
module router_fsm
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       full_state,
    output logic       laf_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy,
    output logic [1:0] addr_q
);

    state_e state, state_nxt;
    logic   empty_sel, soft_sel, empty_hdr, hdr_ok;

    // Address 3 is never a real port, so it selects nothing.
    function automatic logic pick_port(input logic [NUM_PORTS-1:0] v, input logic [1:0] idx);
        case (idx)
            2'd0:    pick_port = v[0];
            2'd1:    pick_port = v[1];
            2'd2:    pick_port = v[2];
            default: pick_port = 1'b0;
        endcase
    endfunction

    assign empty_sel = pick_port({fifo_empty_2, fifo_empty_1, fifo_empty_0}, addr_q);
    assign soft_sel  = pick_port({soft_reset_2, soft_reset_1, soft_reset_0}, addr_q);
    assign empty_hdr = pick_port({fifo_empty_2, fifo_empty_1, fifo_empty_0}, data_in);
    assign hdr_ok    = (state == DECODE_ADDRESS) && pkt_valid && (data_in != ADDR_INVALID);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= DECODE_ADDRESS;
            addr_q <= 2'd0;
        end else begin
            state <= state_nxt;
            if (hdr_ok)
                addr_q <= data_in;
        end
    end

    always_comb begin
        state_nxt = DECODE_ADDRESS;
        case (state)
            DECODE_ADDRESS: begin
                state_nxt = DECODE_ADDRESS;
                if (pkt_valid) begin
                    if (data_in == ADDR_INVALID)
                        state_nxt = DROP_PACKET;
                    else if (empty_hdr)
                        state_nxt = LOAD_FIRST_DATA;
                    else
                        state_nxt = WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY:    state_nxt = empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            LOAD_FIRST_DATA:    state_nxt = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)
                    state_nxt = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    state_nxt = LOAD_PARITY;
                else
                    state_nxt = LOAD_DATA;
            end
            FIFO_FULL_STATE:    state_nxt = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    state_nxt = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    state_nxt = LOAD_PARITY;
                else
                    state_nxt = LOAD_DATA;
            end
            LOAD_PARITY:        state_nxt = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            DROP_PACKET:        state_nxt = pkt_valid ? DROP_PACKET : DECODE_ADDRESS;
            default:            state_nxt = DECODE_ADDRESS;
        endcase
        // A timeout on the selected FIFO abandons the packet mid-flight.
        if (soft_sel && state != DECODE_ADDRESS && state != DROP_PACKET)
            state_nxt = DECODE_ADDRESS;
    end

    always_comb begin
        detect_add    = (state == DECODE_ADDRESS);
        lfd_state     = (state == LOAD_FIRST_DATA);
        ld_state      = (state == LOAD_DATA);
        full_state    = (state == FIFO_FULL_STATE);
        laf_state     = (state == LOAD_AFTER_FULL);
        rst_int_reg   = (state == CHECK_PARITY_ERROR);
        write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) || (state == LOAD_AFTER_FULL);
        busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA) || (state == DROP_PACKET));
    end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: each step checks the registered output vector.
module tb_router_fsm;

    logic       clk = 1'b0;
    logic       rstn, pkt_valid, fifo_full, parity_done, low_pkt_valid;
    logic [1:0] data_in;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       detect_add, lfd_state, ld_state, full_state, laf_state;
    logic       rst_int_reg, write_enb_reg, busy;
    logic [1:0] addr_q;
    logic [7:0] outs;

    int n_tests = 0;
    int n_fail  = 0;

    // {detect_add, lfd, ld, full, laf, rst_int_reg, write_enb_reg, busy}
    localparam logic [7:0] O_DEC  = 8'b1000_0000;
    localparam logic [7:0] O_LFD  = 8'b0100_0001;
    localparam logic [7:0] O_LD   = 8'b0010_0010;
    localparam logic [7:0] O_FULL = 8'b0001_0001;
    localparam logic [7:0] O_LAF  = 8'b0000_1011;
    localparam logic [7:0] O_LP   = 8'b0000_0011;
    localparam logic [7:0] O_CPE  = 8'b0000_0101;
    localparam logic [7:0] O_WTE  = 8'b0000_0001;
    localparam logic [7:0] O_DROP = 8'b0000_0000;

    always #5 clk = ~clk;

    assign outs = {detect_add, lfd_state, ld_state, full_state, laf_state,
                   rst_int_reg, write_enb_reg, busy};

    router_fsm dut (
        .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full),
        .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .full_state(full_state), .laf_state(laf_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy), .addr_q(addr_q)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Advance one edge, then check outputs mid-cycle.
    task automatic step(input string tag, input logic [7:0] exp);
        @(posedge clk);
        #1;
        chk(tag, outs, exp);
    endtask

    initial begin
        rstn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;

        step("reset_outs", O_DEC);
        chk("reset_addr", {6'd0, addr_q}, 8'd1 - 8'd1);
        rstn = 1'b1;

        // Normal packet to port 1: header 0x05
        pkt_valid = 1'b1; data_in = 2'b01;
        step("p1_lfd", O_LFD);
        chk("p1_addr", {6'd0, addr_q}, 8'd1);
        data_in = 2'b10;
        step("p1_ld1", O_LD);
        step("p1_ld2", O_LD);
        step("p1_ld3", O_LD);
        pkt_valid = 1'b0;
        step("p1_lp", O_LP);
        step("p1_cpe", O_CPE);
        step("p1_dec", O_DEC);

        // Port 2 busy: wait for empty
        fifo_empty_2 = 1'b0; pkt_valid = 1'b1; data_in = 2'd2;
        step("p2_wte0", O_WTE);
        pkt_valid = 1'b0;
        for (int i = 1; i < 5; i++) step($sformatf("p2_wte%0d", i), O_WTE);
        chk("p2_addr", {6'd0, addr_q}, 8'd2);
        fifo_empty_2 = 1'b1; pkt_valid = 1'b1;
        step("p2_lfd", O_LFD);
        step("p2_ld", O_LD);
        pkt_valid = 1'b0;
        step("p2_lp", O_LP);
        step("p2_cpe", O_CPE);
        step("p2_dec", O_DEC);

        // Invalid address 3 drops the packet, addr_q keeps 2
        pkt_valid = 1'b1; data_in = 2'd3;
        step("drop0", O_DROP);
        data_in = 2'd1;
        for (int i = 1; i <= 4; i++) step($sformatf("drop%0d", i), O_DROP);
        chk("drop_addr", {6'd0, addr_q}, 8'd2);
        pkt_valid = 1'b0;
        step("drop_dec", O_DEC);

        // FIFO full for 3 cycles mid-payload on port 0
        pkt_valid = 1'b1; data_in = 2'd0;
        step("f_lfd", O_LFD);
        step("f_ld", O_LD);
        fifo_full = 1'b1;
        step("f_full1", O_FULL);
        step("f_full2", O_FULL);
        step("f_full3", O_FULL);
        fifo_full = 1'b0;
        step("f_laf", O_LAF);
        step("f_ld_back", O_LD);
        // full and !pkt_valid together: full wins, then parity via low_pkt_valid
        fifo_full = 1'b1; pkt_valid = 1'b0;
        step("fp_full", O_FULL);
        fifo_full = 1'b0;
        step("fp_laf", O_LAF);
        low_pkt_valid = 1'b1;
        step("fp_lp", O_LP);
        low_pkt_valid = 1'b0;
        step("fp_cpe", O_CPE);
        fifo_full = 1'b1;
        step("cpe_full", O_FULL);
        fifo_full = 1'b0;
        step("cpe_laf", O_LAF);
        parity_done = 1'b1;
        step("laf_done_dec", O_DEC);
        parity_done = 1'b0;

        // Soft reset: ignored in DECODE, unselected port ignored, selected wins
        soft_reset_0 = 1'b1; pkt_valid = 1'b1; data_in = 2'd1;
        step("s_lfd", O_LFD);
        soft_reset_0 = 1'b0;
        step("s_ld", O_LD);
        soft_reset_0 = 1'b1;
        step("s_other_port", O_LD);
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b1; fifo_full = 1'b1;
        step("s_sel_dec", O_DEC);
        soft_reset_1 = 1'b0; fifo_full = 1'b0; pkt_valid = 1'b0;
        step("s_idle", O_DEC);

        // Reset during FIFO full stall
        pkt_valid = 1'b1; data_in = 2'd1;
        step("r_lfd", O_LFD);
        step("r_ld", O_LD);
        fifo_full = 1'b1;
        step("r_full", O_FULL);
        rstn = 1'b0;
        step("r_reset", O_DEC);
        chk("r_addr", {6'd0, addr_q}, 8'd0);
        rstn = 1'b1; fifo_full = 1'b0; pkt_valid = 1'b0;
        step("r_idle", O_DEC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
